// File: rtl/axi_stream_remove_header.sv
// -----------------------------------------------------------------------------
// axi_stream_remove_header
//
// Strips R leading bytes (0..DATA_BYTE_WD-1) from each AXI-Stream packet. The
// remaining bytes are re-packed toward the MSB lane. One strip count is taken
// per packet on the remove side channel.
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   valid_in/ready_in             input beat handshake
//   data_in, keep_in, last_in     input beat (byte 0 = MSB lane, keep MSB = byte 0)
//   valid_out/ready_out           output beat handshake
//   data_out, keep_out, last_out  registered output beat
//   valid_remove/ready_remove     strip-count handshake
//   byte_remove_cnt               bytes to strip from the next packet
// -----------------------------------------------------------------------------
module axi_stream_remove_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    valid_remove,
    output logic                    ready_remove,
    input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HEAD  = 2'd1,
        ST_BODY  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_s;

    logic [BYTE_CNT_WD-1:0]  rem_r;
    logic [DATA_WD-1:0]      carry_data_r;
    logic [DATA_BYTE_WD-1:0] carry_keep_r;

    logic                    load_ok_s;
    logic                    rem_fire_s;
    logic                    carry_load_s;
    logic                    out_load_s;
    logic                    out_flush_s;
    logic                    out_last_s;
    logic                    body_resid_s;
    logic                    head_resid_s;

    logic [BYTE_CNT_WD+2:0]    bit_shift_s;
    logic [2*DATA_WD-1:0]      wide_data_s;
    logic [2*DATA_BYTE_WD-1:0] wide_keep_s;
    logic [DATA_BYTE_WD-1:0]   head_keep_s;
    logic [DATA_WD-1:0]        flush_data_s;
    logic [DATA_BYTE_WD-1:0]   flush_keep_s;

    // Output register can take a new beat when empty or draining this cycle.
    assign load_ok_s  = !valid_out || ready_out;
    assign rem_fire_s = valid_remove && ready_remove;

    // Shift the {previous beat, current beat} pair left by R bytes: the upper
    // half is the realigned output beat, the lower half holds what is left over.
    assign bit_shift_s  = {rem_r, 3'b000};
    assign wide_data_s  = {carry_data_r, data_in} << bit_shift_s;
    assign wide_keep_s  = {carry_keep_r, keep_in} << rem_r;
    assign head_keep_s  = keep_in << rem_r;
    assign flush_data_s = carry_data_r << bit_shift_s;
    assign flush_keep_s = carry_keep_r << rem_r;

    assign body_resid_s = (wide_keep_s[DATA_BYTE_WD-1:0] != {DATA_BYTE_WD{1'b0}});
    // A single-beat packet whose bytes all fall inside the header leaves nothing.
    assign head_resid_s = (head_keep_s != {DATA_BYTE_WD{1'b0}});

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; uses valid_in directly so it never loops through ready_in.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (valid_remove) begin
                    state_s = ST_HEAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HEAD: begin
                if (valid_in) begin
                    if (!last_in) begin
                        state_s = ST_BODY;
                    end else if (head_resid_s) begin
                        state_s = ST_FLUSH;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_HEAD;
                end
            end
            ST_BODY: begin
                if (valid_in && load_ok_s && last_in) begin
                    if (body_resid_s) begin
                        state_s = ST_FLUSH;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_BODY;
                end
            end
            ST_FLUSH: begin
                if (load_ok_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Per-state handshakes and datapath strobes.
    always_comb begin
        ready_in     = 1'b0;
        ready_remove = 1'b0;
        carry_load_s = 1'b0;
        out_load_s   = 1'b0;
        out_flush_s  = 1'b0;
        out_last_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ready_remove = 1'b1;
            end
            ST_HEAD: begin
                // First beat only fills the carry, so no output space is needed.
                ready_in     = 1'b1;
                carry_load_s = valid_in;
            end
            ST_BODY: begin
                ready_in     = load_ok_s;
                carry_load_s = valid_in && load_ok_s;
                out_load_s   = valid_in && load_ok_s;
                out_last_s   = last_in && !body_resid_s;
            end
            ST_FLUSH: begin
                out_load_s  = load_ok_s;
                out_flush_s = 1'b1;
                out_last_s  = 1'b1;
            end
            default: begin
                ready_remove = 1'b0;
            end
        endcase
    end

    // Strip count, carry beat and registered output beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r        <= {BYTE_CNT_WD{1'b0}};
            carry_data_r <= {DATA_WD{1'b0}};
            carry_keep_r <= {DATA_BYTE_WD{1'b0}};
            valid_out    <= 1'b0;
            data_out     <= {DATA_WD{1'b0}};
            keep_out     <= {DATA_BYTE_WD{1'b0}};
            last_out     <= 1'b0;
        end else begin
            if (rem_fire_s) begin
                rem_r <= byte_remove_cnt;
            end
            if (carry_load_s) begin
                carry_data_r <= data_in;
                carry_keep_r <= keep_in;
            end
            if (out_load_s) begin
                valid_out <= 1'b1;
                last_out  <= out_last_s;
                if (out_flush_s) begin
                    data_out <= flush_data_s;
                    keep_out <= flush_keep_s;
                end else begin
                    data_out <= wide_data_s[2*DATA_WD-1:DATA_WD];
                    keep_out <= wide_keep_s[2*DATA_BYTE_WD-1:DATA_BYTE_WD];
                end
            end else if (ready_out) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule
